// File: rtl/csa_resolve_serial.sv
// Chunk-serial carry-propagate resolver for a carry-save (S, Cout) pair, CHUNK bits per cycle.
// Optional macro CSA_RESOLVE_CHECK_EN: flags a nonzero carry LSB (c_in[1]) on the sticky err output.
module csa_resolve_serial #(
    parameter int S_WIDTH = 13,
    parameter int C_WIDTH = 14,
    parameter int CHUNK   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [S_WIDTH:1]     s_in,
    input  logic [C_WIDTH:1]     c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [C_WIDTH+1:1]   result,
    output logic                 err
);

    localparam int OUT_WIDTH = C_WIDTH + 1;
    localparam int NCHUNK    = (C_WIDTH + CHUNK - 1) / CHUNK;
    localparam int LASTW     = C_WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t               state_q;
    logic [C_WIDTH-1:0]   a_q, b_q;
    logic                 carry_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [OUT_WIDTH-1:0] res_q, res_d;
    logic                 in_ready_q, out_valid_q;

    logic [C_WIDTH-1:0]   a_shift, b_shift;
    logic [CHUNK-1:0]     a_chunk, b_chunk;
    logic [CHUNK:0]       chunk_sum;
    logic [OUT_WIDTH-1:0] wmask, wdata;
    logic                 last_chunk;
    logic                 carry_d;
    int                   shamt;

    // Shifting the operands right drops the current chunk into the low bits and
    // feeds zeros above C_WIDTH, so a partial final chunk adds only its valid bits.
    always_comb begin
        shamt      = int'(cnt_q) * CHUNK;
        last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
        a_shift    = a_q >> shamt;
        b_shift    = b_q >> shamt;
        a_chunk    = a_shift[CHUNK-1:0];
        b_chunk    = b_shift[CHUNK-1:0];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        carry_d    = chunk_sum[CHUNK];
        wmask      = OUT_WIDTH'({CHUNK{1'b1}}) << shamt;
        wdata      = OUT_WIDTH'(chunk_sum[CHUNK-1:0]) << shamt;
        res_d      = (res_q & ~wmask) | (wdata & wmask);
        if (last_chunk) begin
            res_d[C_WIDTH] = chunk_sum[LASTW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= C_WIDTH'(s_in);
                        b_q        <= c_in;
                        carry_q    <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ADD;
                    end
                end
                ADD: begin
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_chunk) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CSA_RESOLVE_CHECK_EN
    logic err_q;

    // Sticky until reset; the pair is still accepted and summed exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && in_valid && c_in[1]) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;

endmodule
